// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C master arbiter and the requesters that talk to it.
package i2c_arb_pkg;

    localparam logic [1:0] INST_START_TX   = 2'd0;
    localparam logic [1:0] INST_STOP_TX    = 2'd1;
    localparam logic [1:0] INST_READ_BYTE  = 2'd2;
    localparam logic [1:0] INST_WRITE_BYTE = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_OWNED      = 2'd1,
        ARB_FORCE_STOP = 2'd2,
        ARB_FORCE_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// Round-robin winner search: first eligible index after lastGrant, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      lastGrant,
    output logic               valid,
    output logic [IW-1:0]      winner
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest eligible wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        cand   = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, lastGrant} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (eligible[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one byte-level I2C master among NUM_REQ requesters; ownership spans START..STOP,
// with a watchdog that issues its own STOP when an owner stalls.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*NUM_REQ-1:0]   reqInstruction,
    input  logic [NUM_REQ-1:0]     reqEnable,
    input  logic [8*NUM_REQ-1:0]   reqByteToSend,
    output logic [7:0]             reqByteReceived,
    output logic [NUM_REQ-1:0]     reqComplete,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     timeoutFlag,
    output logic [1:0]             instructionI2C,
    output logic                   enableI2C,
    output logic [7:0]             byteToSendI2C,
    input  logic [7:0]             byteReceivedI2C,
    input  logic                   completeI2C
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_q, last_d;
    logic                stop_seen_q, stop_seen_d;
    logic [CW-1:0]       idle_cnt_q, idle_cnt_d;
    logic                fs_started_q, fs_started_d;
    logic [NUM_REQ-1:0]  tmo_q, tmo_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  own_onehot;
    logic [1:0]          own_inst;
    logic                own_en;
    logic [7:0]          own_byte;

    assign reqByteReceived = byteReceivedI2C;
    assign timeoutFlag     = tmo_q;

    // Per-requester decode and the owner's slice of the request bus.
    always_comb begin
        eligible   = '0;
        own_onehot = '0;
        own_inst   = INST_START_TX;
        own_en     = 1'b0;
        own_byte   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i]   = reqEnable[i] && (reqInstruction[2*i +: 2] == INST_START_TX);
            own_onehot[i] = (owner_q == IW'(i));
            if (owner_q == IW'(i)) begin
                own_inst = reqInstruction[2*i +: 2];
                own_en   = reqEnable[i];
                own_byte = reqByteToSend[8*i +: 8];
            end
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .eligible  (eligible),
        .lastGrant (last_q),
        .valid     (pick_valid),
        .winner    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_q       <= IW'(NUM_REQ - 1);
            stop_seen_q  <= 1'b0;
            idle_cnt_q   <= '0;
            fs_started_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            stop_seen_q  <= stop_seen_d;
            idle_cnt_q   <= idle_cnt_d;
            fs_started_q <= fs_started_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        stop_seen_d    = stop_seen_q;
        idle_cnt_d     = idle_cnt_q;
        fs_started_d   = fs_started_q;
        tmo_d          = tmo_q;
        instructionI2C = INST_START_TX;
        enableI2C      = 1'b0;
        byteToSendI2C  = '0;
        reqComplete    = '1;
        grant          = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    last_d      = pick_idx;
                    stop_seen_d = 1'b0;
                    idle_cnt_d  = '0;
                    state_d     = ARB_OWNED;
                end
            end

            ARB_OWNED: begin
                instructionI2C = own_inst;
                enableI2C      = own_en;
                byteToSendI2C  = own_byte;
                reqComplete    = ~own_onehot | {NUM_REQ{completeI2C}};
                grant          = own_onehot;
                if (own_en) begin
                    idle_cnt_d = '0;
                    if (own_inst == INST_STOP_TX) begin
                        stop_seen_d = 1'b1;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                    if (stop_seen_q) begin
                        state_d = ARB_IDLE;
                    end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                        tmo_d        = tmo_q | own_onehot;
                        fs_started_d = 1'b0;
                        state_d      = ARB_FORCE_STOP;
                    end
                end
            end

            // Watchdog STOP: wait for the master to go busy, then for it to finish.
            ARB_FORCE_STOP: begin
                instructionI2C = INST_STOP_TX;
                enableI2C      = 1'b1;
                if (!completeI2C) begin
                    fs_started_d = 1'b1;
                end else if (fs_started_q) begin
                    state_d = ARB_FORCE_DONE;
                end
            end

            ARB_FORCE_DONE: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
